// File: rtl/core_pkg.sv
// core_pkg
// Shared definitions for the memory port arbiter slice.
//   WORD_W      : width of addresses and data words on every port
//   ret_state_e : owner of the read data returning from the memory
//                 one cycle after a grant
package core_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    RET_NONE = 2'd0,
    RET_IF   = 2'd1,
    RET_DM   = 2'd2
  } ret_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch port, data port and memory-side signals of the arbiter.
//   fetch  : if_req, if_addr -> if_gnt, if_rdata, if_rvalid, stall_if
//   data   : dm_req, dm_we, dm_addr, dm_wdata -> dm_gnt, dm_rdata, dm_rvalid
//   memory : mem_en, mem_we, mem_addr, mem_wdata -> mem_rdata
// Modports:
//   master : the core pipeline plus memory (drives requests and mem_rdata)
//   slave  : the arbiter (drives grants, returns and the memory command)
interface mem_port_arbiter_if;
  import core_pkg::*;

  logic              if_req;
  logic [WORD_W-1:0] if_addr;
  logic              if_gnt;
  logic [WORD_W-1:0] if_rdata;
  logic              if_rvalid;
  logic              stall_if;

  logic              dm_req;
  logic              dm_we;
  logic [WORD_W-1:0] dm_addr;
  logic [WORD_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic [WORD_W-1:0] dm_rdata;
  logic              dm_rvalid;

  logic              mem_en;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rdata, if_rvalid, stall_if,
           dm_gnt, dm_rdata, dm_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rdata, if_rvalid, stall_if,
           dm_gnt, dm_rdata, dm_rvalid,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_starve_counter.sv
// arb_starve_counter
// Counts consecutive cycles in which a pending fetch lost the memory port
// to the data stage. Saturates at STARVE_LIMIT.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   if_req     : fetch is requesting this cycle
//   if_gnt     : fetch was granted this cycle
//   dm_gnt     : data was granted this cycle
//   cnt        : current starvation count
module arb_starve_counter #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic             if_gnt,
  input  logic             dm_gnt,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any cycle where fetch is idle or wins ends the losing streak.
  always_comb begin
    cnt_d = cnt_q;
    if (!if_req || if_gnt) begin
      cnt_d = '0;
    end else if (dm_gnt && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory between instruction fetch and
// the data stage. Data normally wins; fetch is forced through once it has
// lost STARVE_LIMIT cycles in a row. Read data returns one cycle after the
// grant and is steered to whichever port issued the read.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of mem_port_arbiter_if (fetch, data and memory
//           signals)
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  // A limit of zero still needs a one-bit counter; it simply never leaves 0,
  // which makes fetch win every conflict.
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  logic             if_gnt_c;
  logic             dm_gnt_c;
  logic             dm_rd_gnt;

  logic              mem_en_c;
  logic              mem_we_c;
  logic [WORD_W-1:0] mem_addr_c;
  logic [WORD_W-1:0] mem_wdata_c;

  logic              if_rvalid_c;
  logic              dm_rvalid_c;
  logic [WORD_W-1:0] if_rdata_c;
  logic [WORD_W-1:0] dm_rdata_c;

  ret_state_e ret_q;
  ret_state_e ret_d;

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .if_req (bus.if_req),
    .if_gnt (if_gnt_c),
    .dm_gnt (dm_gnt_c),
    .cnt    (starve_cnt)
  );

  // Grant decision: data first unless fetch has starved long enough.
  // Reset masks both grants so nothing reaches the memory.
  always_comb begin
    starve_hit = bus.if_req && (starve_cnt == LIMIT);
    dm_gnt_c   = !reset && bus.dm_req && !starve_hit;
    if_gnt_c   = !reset && bus.if_req && !dm_gnt_c;
    dm_rd_gnt  = dm_gnt_c && !bus.dm_we;
  end

  // Memory command mux; the bus is driven to all zeros when idle.
  always_comb begin
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    if (dm_gnt_c) begin
      mem_en_c    = 1'b1;
      mem_we_c    = bus.dm_we;
      mem_addr_c  = bus.dm_addr;
      mem_wdata_c = bus.dm_wdata;
    end else if (if_gnt_c) begin
      mem_en_c    = 1'b1;
      mem_addr_c  = bus.if_addr;
    end
  end

  // Return-owner state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ret_q <= RET_NONE;
    end else begin
      ret_q <= ret_d;
    end
  end

  // Next return owner; writes produce no return.
  always_comb begin
    ret_d = RET_NONE;
    if (if_gnt_c) begin
      ret_d = RET_IF;
    end else if (dm_rd_gnt) begin
      ret_d = RET_DM;
    end
  end

  // Steer returning read data; a read in flight when reset asserts is
  // dropped here, and the state clear on the same edge stops it later.
  always_comb begin
    if_rvalid_c = !reset && (ret_q == RET_IF);
    dm_rvalid_c = !reset && (ret_q == RET_DM);
    if_rdata_c  = if_rvalid_c ? bus.mem_rdata : '0;
    dm_rdata_c  = dm_rvalid_c ? bus.mem_rdata : '0;
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.dm_gnt    = dm_gnt_c;
  assign bus.stall_if  = bus.if_req && !if_gnt_c && !reset;
  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.if_rvalid = if_rvalid_c;
  assign bus.if_rdata  = if_rdata_c;
  assign bus.dm_rvalid = dm_rvalid_c;
  assign bus.dm_rdata  = dm_rdata_c;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: max consecutive cycles fetch may lose to data before forced fetch grant.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have if_req  input  1  fetch stage requests an instruction read.
REQ-005 SHALL have if_addr  input  16  fetch read address.
REQ-006 SHALL have if_gnt  output  1  fetch request accepted this cycle.
REQ-007 SHALL have if_rdata  output  16  instruction word returned to fetch.
REQ-008 SHALL have if_rvalid  output  1  if_rdata valid this cycle.
REQ-009 SHALL have stall_if  output  1  fetch must hold PC and bubble decode; equals if_req and not if_gnt.
REQ-010 SHALL have dm_req, dm_we  input  1 each  data stage request; dm_we=1 write, 0 read.
REQ-011 SHALL have dm_addr, dm_wdata  input  16 each  data address, write data.
REQ-012 SHALL have dm_gnt  output  1  data request accepted this cycle.
REQ-013 SHALL have dm_rdata  output  16, dm_rvalid  output  1  load data return and valid.
REQ-014 SHALL have mem_en, mem_we  output  1 each; mem_addr, mem_wdata  output  16 each; mem_rdata  input  16  single-port synchronous memory, read data one cycle after mem_en.

Function
REQ-015 SHALL grant at most one requester per cycle; grant decision combinational from requests and starvation counter.
REQ-016 SHALL grant data when dm_req=1, unless starve_cnt equals STARVE_LIMIT and if_req=1, in which case fetch is granted.
REQ-017 SHALL grant fetch when if_req=1 and data not granted.
REQ-018 SHALL drive mem_en=1 in any granted cycle, mem_addr/mem_wdata/mem_we from the granted requester; mem_we=1 only on granted data write; mem_en=0 and mem_addr/mem_wdata/mem_we=0 when idle.
REQ-019 SHALL track return owner in a 2-bit registered state: RET_NONE, RET_IF, RET_DM; next state RET_IF on fetch grant, RET_DM on data read grant, RET_NONE otherwise (including data write grant).
REQ-020 SHALL assert if_rvalid exactly one cycle after fetch grant with if_rdata=mem_rdata; if_rdata=0 otherwise.
REQ-021 SHALL assert dm_rvalid exactly one cycle after data read grant with dm_rdata=mem_rdata; dm_rdata=0 otherwise; never for writes.
REQ-022 SHALL increment starve_cnt (width clog2(STARVE_LIMIT+1)) when if_req=1 and data granted; clear on fetch grant or if_req=0; saturate at STARVE_LIMIT.
REQ-023 SHALL, with back-to-back grants, sustain one access per cycle; return of cycle N and grant of cycle N+1 overlap without bubble.
REQ-024 SHALL keep requesters responsible for holding req/addr/wdata stable until gnt; an ungranted request causes no memory access and no state change besides starve_cnt.
REQ-025 SHALL treat STARVE_LIMIT=0 as fetch always priority over data when both request.

Reset
REQ-026 SHALL, while reset=1, force if_gnt, dm_gnt, mem_en, mem_we, if_rvalid, dm_rvalid, stall_if to 0 and suppress any memory access.
REQ-027 SHALL on reset clear return state to RET_NONE and starve_cnt to 0; read in flight when reset asserts is discarded, no rvalid follows.
REQ-028 SHALL resume arbitration on the first cycle after reset deasserts.

Structure
REQ-029 SHALL place return-state encoding (RET_NONE=0, RET_IF=1, RET_DM=2) and word width constant 16 in shared package core_pkg.
REQ-030 SHALL be a single module; starvation counter MAY be a sub-module arb_starve_counter.

Verification
REQ-031 Fetch only: if_req=1, if_addr=0x0004, mem_rdata=0xA123 next cycle -> if_gnt=1, mem_addr=0x0004, next cycle if_rvalid=1, if_rdata=0xA123, stall_if=0.
REQ-032 Conflict: if_req=1, dm_req=1 read dm_addr=0x0008 -> dm_gnt=1, stall_if=1, next cycle dm_rvalid=1, if_rvalid=0.
REQ-033 Starvation: both requesting continuously, STARVE_LIMIT=3 -> grants DM,DM,DM,IF,DM,DM,DM,IF...
REQ-034 Write: dm_req=1, dm_we=1, dm_addr=0x0002, dm_wdata=0x55AA -> mem_we=1, mem_wdata=0x55AA, no dm_rvalid next cycle.
REQ-035 Reset mid-read: fetch granted cycle N, reset=1 cycle N+1 -> if_rvalid=0 cycle N+1, starve_cnt=0, all outputs 0.
REQ-036 Back-to-back: fetch grants 0x0000,0x0001,0x0002 consecutive cycles -> three consecutive if_rvalid pulses in order.
